branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_pkg.sv | 39 +++
 rtl/cond_eval.sv | 44 ++++
 rtl/zero_detect.sv | 26 ++
 rtl/branch_resolve.sv | 112 +++++++++++
 tb/tb_branch_resolve.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// Shared branch-resolution types: branch kinds, condition codes, flag bit positions.
// Pure definitions; no logic, no latency, no flow control.
package branch_pkg;

    typedef enum logic [1:0] {
        BR_B     = 2'd0,
        BR_CBZ   = 2'd1,
        BR_CBNZ  = 2'd2,
        BR_BCOND = 2'd3
    } br_type_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } br_state_t;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_HS = 4'h2;
    localparam logic [3:0] COND_LO = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// Condition-code evaluator against an {N,Z,C,V} flag vector.
// Combinational, zero latency; no flow control.
module cond_eval
    import branch_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;
    logic hi, ge, gt;

    assign n  = flags[FLAG_N];
    assign z  = flags[FLAG_Z];
    assign c  = flags[FLAG_C];
    assign v  = flags[FLAG_V];
    assign hi = c & ~z;
    assign ge = (n == v);
    assign gt = ~z & ge;

    always_comb begin
        pass = 1'b1;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_HS: pass = c;
            COND_LO: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = hi;
            COND_LS: pass = ~hi;
            COND_GE: pass = ge;
            COND_LT: pass = ~ge;
            COND_GT: pass = gt;
            COND_LE: pass = ~gt;
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/zero_detect.sv
// Structural all-zero detect: byte-group OR tree, then a final NOR.
// Combinational, zero latency; no flow control.
module zero_detect #(
    parameter int W = 64
) (
    input  logic [W-1:0] value,
    output logic         zero
);

    localparam int NG = (W + 7) / 8;

    logic [NG*8-1:0] padded;
    logic [NG-1:0]   grp_any;

    always_comb begin
        padded        = '0;
        padded[W-1:0] = value;
    end

    for (genvar g = 0; g < NG; g++) begin : g_grp
        assign grp_any[g] = |padded[g*8 +: 8];
    end

    assign zero = ~|grp_any;

endmodule

// File: rtl/branch_resolve.sv
// Resolves ID-stage branches (B/CBZ/CBNZ/BCOND) and owns the NZCV register; latency 1.
// stall holds a resolved result and blocks new requests/flag writes; flush squashes output.
module branch_resolve
    import branch_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              setFlags,
    input  logic [DATA_W-1:0] aluResult,
    input  logic [2:0]        aluNCV,
    input  logic              brValid,
    input  logic [1:0]        brType,
    input  logic [3:0]        cond,
    input  logic [DATA_W-1:0] operand,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] offset,
    input  logic              stall,
    input  logic              flush,
    output logic [3:0]        flags,
    output logic              outValid,
    output logic              taken,
    output logic [ADDR_W-1:0] target
);

    logic              alu_zero;
    logic              opnd_zero;
    logic              cond_pass;
    logic              br_taken;
    logic              accept;
    logic [3:0]        fwd_flags;
    logic [3:0]        eff_flags;
    logic [ADDR_W-1:0] br_target;
    br_state_t         state;
    br_state_t         next_state;

    zero_detect #(.W(DATA_W)) u_alu_zd (
        .value (aluResult),
        .zero  (alu_zero)
    );

    zero_detect #(.W(DATA_W)) u_opnd_zd (
        .value (operand),
        .zero  (opnd_zero)
    );

    // A flag-setter in EX this cycle is forwarded so a dependent BCOND need not wait.
    assign fwd_flags = {aluNCV[2], alu_zero, aluNCV[1], aluNCV[0]};
    assign eff_flags = setFlags ? fwd_flags : flags;

    cond_eval u_cond (
        .cond  (cond),
        .flags (eff_flags),
        .pass  (cond_pass)
    );

    always_comb begin
        br_taken = 1'b0;
        case (br_type_t'(brType))
            BR_B:     br_taken = 1'b1;
            BR_CBZ:   br_taken = opnd_zero;
            BR_CBNZ:  br_taken = ~opnd_zero;
            BR_BCOND: br_taken = cond_pass;
        endcase
    end

    assign br_target = br_taken ? (pc + offset) : (pc + ADDR_W'(4));
    assign accept    = brValid & ~stall & ~flush;

    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_IDLE:  next_state = accept ? ST_VALID : ST_IDLE;
            ST_VALID: next_state = (stall || accept) ? ST_VALID : ST_IDLE;
        endcase
        if (flush) begin
            next_state = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= 4'b0000;
        end else if (setFlags && !stall) begin
            flags <= fwd_flags;
        end
    end

    // Result registers load only on acceptance, so a stalled VALID holds them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken  <= 1'b0;
            target <= '0;
        end else if (accept) begin
            taken  <= br_taken;
            target <= br_target;
        end
    end

    assign outValid = (state == ST_VALID);

endmodule

// File: tb/tb_branch_resolve.sv
// Directed table, hand sequences and randomized traffic against a behavioural model.
module tb_branch_resolve;

    logic        clk;
    logic        rst_n;
    logic        setFlags;
    logic [63:0] aluResult;
    logic [2:0]  aluNCV;
    logic        brValid;
    logic [1:0]  brType;
    logic [3:0]  cond;
    logic [63:0] operand;
    logic [63:0] pc;
    logic [63:0] offset;
    logic        stall;
    logic        flush;
    logic [3:0]  flags;
    logic        outValid;
    logic        taken;
    logic [63:0] target;

    int checks = 0;
    int errors = 0;

    bit          m_valid;
    bit          m_taken;
    logic [63:0] m_target;
    logic [3:0]  m_flags;

    branch_resolve #(.DATA_W(64), .ADDR_W(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .setFlags  (setFlags),
        .aluResult (aluResult),
        .aluNCV    (aluNCV),
        .brValid   (brValid),
        .brType    (brType),
        .cond      (cond),
        .operand   (operand),
        .pc        (pc),
        .offset    (offset),
        .stall     (stall),
        .flush     (flush),
        .flags     (flags),
        .outValid  (outValid),
        .taken     (taken),
        .target    (target)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Codes pair up as (condition, its negation); the top pair is always-true.
    function automatic bit m_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic model_reset();
        m_valid  = 1'b0;
        m_taken  = 1'b0;
        m_target = '0;
        m_flags  = 4'b0000;
    endtask

    task automatic cycle();
        logic [3:0]  fwd, eff;
        bit          tk, acc, nv;
        logic [63:0] tg;
        fwd = {aluNCV[2], (aluResult == 64'd0), aluNCV[1], aluNCV[0]};
        eff = setFlags ? fwd : m_flags;
        case (brType)
            2'd0:    tk = 1'b1;
            2'd1:    tk = (operand == 64'd0);
            2'd2:    tk = (operand != 64'd0);
            default: tk = m_pass(cond, eff);
        endcase
        tg  = tk ? pc + offset : pc + 64'd4;
        acc = brValid && !stall && !flush;
        nv  = flush ? 1'b0 : ((m_valid && stall) ? 1'b1 : acc);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (acc) begin
                m_taken  = tk;
                m_target = tg;
            end
            if (setFlags && !stall) m_flags = fwd;
            m_valid = nv;
        end
        #1;
        chk("m_outValid", 64'(outValid), 64'(m_valid));
        chk("m_flags", 64'(flags), 64'(m_flags));
        if (m_valid) begin
            chk("m_taken", 64'(taken), 64'(m_taken));
            chk("m_target", target, m_target);
        end
    endtask

    task automatic idle_inputs();
        setFlags = 0; aluResult = 64'd1; aluNCV = 3'b000; brValid = 0; brType = 2'd0;
        cond = 4'h0; operand = 64'd0; pc = 64'd0; offset = 64'd0; stall = 0; flush = 0;
    endtask

    task automatic expect_all_zero(input string tag);
        chk({tag, "_outValid"}, 64'(outValid), 64'd0);
        chk({tag, "_taken"}, 64'(taken), 64'd0);
        chk({tag, "_target"}, target, 64'd0);
        chk({tag, "_flags"}, 64'(flags), 64'd0);
    endtask

    typedef struct {
        bit          fwd;
        logic [63:0] alu;
        logic [2:0]  ncv;
        logic [1:0]  typ;
        logic [3:0]  cnd;
        logic [63:0] opnd;
        logic [63:0] pcv;
        logic [63:0] off;
        bit          exp_taken;
        logic [63:0] exp_target;
        logic [3:0]  exp_flags;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{1, 64'h0, 3'b000, 2'd3, 4'h0, 64'h0, 64'h1000, 64'h20, 1, 64'h1020, 4'b0100};
        vecs[1]  = '{0, 64'h1, 3'b000, 2'd2, 4'h0, 64'h1, 64'h100, 64'h40, 1, 64'h140, 4'b0000};
        vecs[2]  = '{0, 64'h1, 3'b000, 2'd2, 4'h0, 64'h0, 64'h100, 64'h40, 0, 64'h104, 4'b0000};
        vecs[3]  = '{0, 64'h1, 3'b000, 2'd0, 4'h1, 64'h9, 64'hFFFF_FFFF_FFFF_FFF8, 64'h10, 1, 64'h8, 4'b0000};
        vecs[4]  = '{0, 64'h5, 3'b100, 2'd3, 4'hA, 64'h0, 64'h300, 64'h80, 0, 64'h304, 4'b1000};
        vecs[5]  = '{0, 64'h5, 3'b100, 2'd3, 4'hB, 64'h0, 64'h300, 64'h80, 1, 64'h380, 4'b1000};
        vecs[6]  = '{0, 64'h1, 3'b000, 2'd1, 4'h1, 64'h0, 64'h200, 64'hFFFF_FFFF_FFFF_FFF0, 1, 64'h1F0, 4'b0000};
        vecs[7]  = '{0, 64'h1, 3'b010, 2'd3, 4'h8, 64'h0, 64'h400, 64'h100, 1, 64'h500, 4'b0010};
        vecs[8]  = '{0, 64'h0, 3'b010, 2'd3, 4'h9, 64'h0, 64'h400, 64'h100, 1, 64'h500, 4'b0110};
        vecs[9]  = '{0, 64'h1, 3'b000, 2'd3, 4'hF, 64'h0, 64'h10, 64'h20, 1, 64'h30, 4'b0000};
        vecs[10] = '{1, 64'h0, 3'b000, 2'd3, 4'h1, 64'h0, 64'h10, 64'h20, 0, 64'h14, 4'b0100};
        vecs[11] = '{0, 64'h0, 3'b000, 2'd1, 4'h0, 64'h7, 64'h10, 64'h20, 0, 64'h14, 4'b0100};
        vecs[12] = '{1, 64'h3, 3'b001, 2'd3, 4'h6, 64'h0, 64'h0, 64'h40, 1, 64'h40, 4'b0001};
        vecs[13] = '{1, 64'h3, 3'b101, 2'd3, 4'hC, 64'h0, 64'h20, 64'h8, 1, 64'h28, 4'b1001};

        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        #1;
        expect_all_zero("por");
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();

        foreach (vecs[i]) begin
            idle_inputs();
            if (!vecs[i].fwd) begin
                setFlags = 1; aluResult = vecs[i].alu; aluNCV = vecs[i].ncv;
                cycle();
            end
            setFlags  = vecs[i].fwd;
            aluResult = vecs[i].alu;
            aluNCV    = vecs[i].ncv;
            brValid   = 1;
            brType    = vecs[i].typ;
            cond      = vecs[i].cnd;
            operand   = vecs[i].opnd;
            pc        = vecs[i].pcv;
            offset    = vecs[i].off;
            cycle();
            chk($sformatf("vec%0d_outValid", i), 64'(outValid), 64'd1);
            chk($sformatf("vec%0d_taken", i), 64'(taken), 64'(vecs[i].exp_taken));
            chk($sformatf("vec%0d_target", i), target, vecs[i].exp_target);
            chk($sformatf("vec%0d_flags", i), 64'(flags), 64'(vecs[i].exp_flags));
        end

        // Stall holds a resolved result and blocks flag writes; flush then squashes.
        idle_inputs();
        setFlags = 1; aluResult = 64'h1; aluNCV = 3'b000;
        brValid = 1; brType = 2'd0; pc = 64'h500; offset = 64'h8;
        cycle();
        chk("stall_pre_target", target, 64'h508);
        stall = 1; setFlags = 1; aluResult = 64'h0; aluNCV = 3'b111;
        brType = 2'd1; operand = 64'h5; pc = 64'h900;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk($sformatf("stall%0d_outValid", k), 64'(outValid), 64'd1);
            chk($sformatf("stall%0d_taken", k), 64'(taken), 64'd1);
            chk($sformatf("stall%0d_target", k), target, 64'h508);
            chk($sformatf("stall%0d_flags", k), 64'(flags), 64'd0);
        end
        stall = 0; flush = 1;
        cycle();
        chk("flush_outValid", 64'(outValid), 64'd0);
        chk("flush_flags", 64'(flags), 64'hF);

        // Asynchronous reset between edges while a result is valid.
        idle_inputs();
        brValid = 1; brType = 2'd0; pc = 64'h10; offset = 64'h4;
        cycle();
        chk("prerst_outValid", 64'(outValid), 64'd1);
        idle_inputs();
        #3;
        rst_n = 1'b0;
        #1;
        expect_all_zero("midrst");
        model_reset();
        cycle();
        cycle();
        rst_n = 1'b1;
        brValid = 1; brType = 2'd2; operand = 64'h3; pc = 64'h700; offset = 64'h30;
        cycle();
        chk("postrst_outValid", 64'(outValid), 64'd1);
        chk("postrst_target", target, 64'h730);

        for (int k = 0; k < 400; k++) begin
            setFlags  = ($urandom_range(0, 2) == 0);
            aluResult = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
            aluNCV    = 3'($urandom_range(0, 7));
            brValid   = ($urandom_range(0, 2) != 0);
            brType    = 2'($urandom_range(0, 3));
            cond      = 4'($urandom_range(0, 15));
            operand   = ($urandom_range(0, 2) == 0) ? 64'd0 : {$urandom, $urandom};
            pc        = {$urandom, $urandom};
            offset    = {$urandom, $urandom};
            stall     = ($urandom_range(0, 4) == 0);
            flush     = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
